// File: rtl/imm_ext_pipe_if.sv
// Valid/ready stream bundle for the immediate-extension stage: raw immediate in,
// extended operand out.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: zero/sign/sign-shl1/high modes, registered output
// with a one-entry skid buffer and a wrapping count of completed output transfers.
module imm_ext_pipe #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  imm_ext_pipe_if.slave    bus,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_res;
  logic             out_valid_q, skid_valid_q, in_ready_q;
  logic [OUT_W-1:0] out_data_q, skid_data_q;
  logic             out_valid_n, skid_valid_n;
  logic [OUT_W-1:0] out_data_n, skid_data_n;
  logic             pop, push;

  always_comb begin
    ext_sign = {{(OUT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    case (bus.in_mode)
      2'b00:   ext_res = {{(OUT_W-IN_W){1'b0}}, bus.in_data};
      2'b01:   ext_res = ext_sign;
      2'b10:   ext_res = {ext_sign[OUT_W-2:0], 1'b0};
      default: ext_res = {bus.in_data, {(OUT_W-IN_W){1'b0}}};
    endcase
  end

  assign pop  = out_valid_q & bus.out_ready;
  assign push = bus.in_valid & in_ready_q;

  always_comb begin
    out_valid_n  = out_valid_q;
    out_data_n   = out_data_q;
    skid_valid_n = skid_valid_q;
    skid_data_n  = skid_data_q;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        out_data_n = skid_data_q;
        if (push) skid_data_n = ext_res;
        else      skid_valid_n = 1'b0;
      end else if (push) begin
        out_data_n = ext_res;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (push) begin
      if (out_valid_q) begin
        skid_valid_n = 1'b1;
        skid_data_n  = ext_res;
      end else begin
        out_valid_n = 1'b1;
        out_data_n  = ext_res;
      end
    end
  end

  // in_ready is its own flop so downstream ready never reaches upstream combinationally
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      xfer_cnt     <= '0;
    end else begin
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      skid_valid_q <= skid_valid_n;
      skid_data_q  <= skid_data_n;
      in_ready_q   <= ~skid_valid_n;
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and random-soak bench for imm_ext_pipe; a 4-bit-counter instance
// covers counter wrap.
module tb_imm_ext_pipe;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;
  int          checks;
  int          errors;

  imm_ext_pipe_if #(.IN_W(5), .OUT_W(16)) bus ();
  imm_ext_pipe_if #(.IN_W(5), .OUT_W(16)) bus4 ();

  imm_ext_pipe #(.IN_W(5), .OUT_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .xfer_cnt(xfer_cnt)
  );

  imm_ext_pipe #(.IN_W(5), .OUT_W(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus4), .xfer_cnt(xfer_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_ext(input logic [4:0] d, input logic [1:0] m);
    int s;
    s = d[4] ? int'(d) - 32 : int'(d);
    case (m)
      2'd0:    return 16'(int'(d));
      2'd1:    return 16'(s);
      2'd2:    return 16'(s * 2);
      default: return {d, 11'b0};
    endcase
  endfunction

  logic [15:0] q[$];
  logic [15:0] exp_val;
  logic [15:0] exp_cnt;
  logic        s_pop, s_push;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_mode = '0;  bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_mode = '0; bus4.out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    rst = 1'b1;

    // extension modes, one result per edge
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data = 5'b10110; bus.in_mode = 2'd0; cyc();
    chk("mode_zero_valid", bus.out_valid, 1);
    chk("mode_zero", bus.out_data, 16'h0016);
    bus.in_mode = 2'd1; cyc();
    chk("mode_sign_neg", bus.out_data, 16'hFFF6);
    bus.in_mode = 2'd2; cyc();
    chk("mode_shl1_neg", bus.out_data, 16'hFFEC);
    bus.in_mode = 2'd3; cyc();
    chk("mode_high", bus.out_data, 16'hB000);
    bus.in_data = 5'b01111; bus.in_mode = 2'd1; cyc();
    chk("mode_sign_pos", bus.out_data, 16'h000F);
    bus.in_mode = 2'd2; cyc();
    chk("mode_shl1_pos", bus.out_data, 16'h001E);
    chk("mode_shl1_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0; cyc();
    chk("mode_drain_valid", bus.out_valid, 0);
    chk("mode_xfer_cnt", xfer_cnt, 6);

    // backpressure: A, B held; C stalls upstream
    rst = 1'b0; cyc(); rst = 1'b1;
    chk("bp_cnt_cleared", xfer_cnt, 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_mode = 2'd0;
    bus.in_data = 5'd1; cyc();
    chk("bp_a_valid", bus.out_valid, 1);
    chk("bp_a_in_ready", bus.in_ready, 1);
    bus.in_data = 5'd2; cyc();
    chk("bp_full_in_ready", bus.in_ready, 0);
    bus.in_data = 5'd3; cyc();
    chk("bp_c_stalled_ready", bus.in_ready, 0);
    chk("bp_a_held", bus.out_data, 16'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_out_a", bus.out_data, 16'd1);
    cyc();
    chk("bp_out_b_valid", bus.out_valid, 1);
    chk("bp_out_b", bus.out_data, 16'd2);
    chk("bp_ready_back", bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
    chk("bp_out_c_valid", bus.out_valid, 1);
    chk("bp_out_c", bus.out_data, 16'd3);
    cyc();
    chk("bp_empty", bus.out_valid, 0);
    chk("bp_xfer_cnt", xfer_cnt, 3);

    // flush with both entries occupied
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 5'd10; cyc();
    bus.in_data = 5'd11; cyc();
    chk("fl_full", bus.in_ready, 0);
    flush = 1'b1; bus.in_data = 5'd12; cyc();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_out_data_held", bus.out_data, 16'd10);
    chk("fl_xfer_cnt", xfer_cnt, 3);
    cyc();
    chk("fl_no_capture", bus.out_valid, 0);

    // reset mid-operation with xfer_cnt at 5
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 5'd20; cyc();
    bus.in_data = 5'd21; cyc();
    bus.in_valid = 1'b0; cyc();
    chk("rm_xfer_cnt5", xfer_cnt, 5);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 5'd22; cyc();
    bus.in_data = 5'd23; cyc();
    chk("rm_full", bus.in_ready, 0);
    rst = 1'b0; bus.in_data = 5'd24; cyc();
    rst = 1'b1;
    chk("rm_out_valid", bus.out_valid, 0);
    chk("rm_out_data", bus.out_data, 0);
    chk("rm_in_ready", bus.in_ready, 1);
    chk("rm_xfer_cnt", xfer_cnt, 0);
    bus.out_ready = 1'b1;
    bus.in_data = 5'b10001; bus.in_mode = 2'd1; cyc();
    bus.in_valid = 1'b0;
    chk("rm_first_valid", bus.out_valid, 1);
    chk("rm_first_data", bus.out_data, 16'hFFF1);
    cyc();
    chk("rm_first_cnt", xfer_cnt, 1);

    // 4-bit counter wraps after 16 transfers
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus4.in_data = 5'(i);
      cyc();
    end
    bus4.in_valid = 1'b0;
    chk("wrap_last_data", bus4.out_data, 16'd16);
    cyc();
    chk("wrap_xfer_cnt", xfer_cnt4, 1);
    chk("wrap_empty", bus4.out_valid, 0);

    // random soak against a queue model
    exp_cnt = 16'd1;
    for (int i = 0; i < 320; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 5'($urandom);
      bus.in_mode   = 2'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      #5;
      chk("soak_no_x", 32'($isunknown({bus.out_valid, bus.in_ready, bus.out_data, xfer_cnt})), 0);
      chk("soak_out_valid", bus.out_valid, (q.size() != 0));
      chk("soak_in_ready", bus.in_ready, (q.size() < 2));
      s_pop  = bus.out_valid & bus.out_ready;
      s_push = bus.in_valid & bus.in_ready & ~flush;
      if (s_pop) begin
        if (q.size() == 0) begin
          chk("soak_pop_empty", 1, 0);
        end else begin
          exp_val = q.pop_front();
          chk("soak_data", bus.out_data, exp_val);
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (flush) q.delete();
      else if (s_push) q.push_back(ref_ext(bus.in_data, bus.in_mode));
      @(posedge clk);
      #1;
      chk("soak_xfer_cnt", xfer_cnt, exp_cnt);
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
